// File: rtl/puf_input_network_pipe_if.sv
// Challenge-path bus for the PUF input network: request side (data/mode in),
// challenge side (transformed word out) and status.
interface puf_input_network_pipe_if #(
    parameter int WIDTH = 64,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] dataIn;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dataOut;
    logic             busy;
    logic [CNT_W-1:0] chal_cnt;

    modport master (
        output in_valid, dataIn, mode, out_ready,
        input  in_ready, out_valid, dataOut, busy, chal_cnt
    );

    modport slave (
        input  in_valid, dataIn, mode, out_ready,
        output in_ready, out_valid, dataOut, busy, chal_cnt
    );
endinterface

// File: rtl/puf_input_network_pipe.sv
// Registered SAC input network: bypass, single SAC pass, or ROUNDS iterated
// passes (one per clock), delivered as a challenge with valid/ready.
module puf_input_network_pipe #(
    parameter int WIDTH  = 64,
    parameter int ROUNDS = 4,
    parameter int CNT_W  = 16
) (
    input logic                     clk,
    input logic                     reset,
    puf_input_network_pipe_if.slave bus
);
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ITER = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;
    localparam logic [7:0] LAST_RND = 8'(ROUNDS - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic [7:0]       rnd_q, rnd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sac_in, sac_out;

    // One shared SAC network: fed by the input word in IDLE, by its own result in ITER.
    assign sac_in = (state_q == ST_ITER) ? data_q : bus.dataIn;

    assign sac_out[WIDTH/2] = sac_in[0];
    assign sac_out[0]       = sac_in[0] ^ sac_in[WIDTH-1];

    for (genvar g = 1; g <= WIDTH - 3; g += 2) begin : g_odd
        assign sac_out[(g+1)/2] = sac_in[g] ^ sac_in[g+1];
    end

    for (genvar g = 2; g <= WIDTH - 2; g += 2) begin : g_even
        assign sac_out[(WIDTH+g)/2] = sac_in[g] ^ sac_in[g+1];
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rnd_d   = rnd_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    if (bus.mode == 2'd0) begin
                        data_d  = bus.dataIn;
                        state_d = ST_HOLD;
                    end else if (bus.mode == 2'd2) begin
                        data_d  = sac_out;
                        rnd_d   = 8'd1;
                        state_d = ST_ITER;
                    end else begin
                        data_d  = sac_out;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_ITER: begin
                data_d = sac_out;
                rnd_d  = rnd_q + 8'd1;
                // rnd_q counts passes already applied; this cycle's pass is the last one.
                if (rnd_q == LAST_RND) state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            rnd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rnd_q   <= rnd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_IDLE);
    assign bus.out_valid = (state_q == ST_HOLD);
    assign bus.busy      = (state_q == ST_ITER);
    assign bus.dataOut   = data_q;
    assign bus.chal_cnt  = cnt_q;
endmodule
